accel_position_filter: RTL and testbench



---
 rtl/accel_position_filter_pkg.sv | 15 +
 rtl/accel_position_filter_axis_avg_window.sv | 77 +++++++
 rtl/accel_position_filter.sv | 141 ++++++++++++++
 tb/tb_accel_position_filter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/accel_position_filter_pkg.sv
// Shared widths, reset constants and sequencing states for the accelerometer position filter.
package accel_position_filter_pkg;

   localparam int unsigned ACCEL_W = 9;
   localparam logic [ACCEL_W-1:0] POS_CENTER = 9'd256;

   typedef enum logic [2:0] {
      PRIME   = 3'd0,
      IDLE    = 3'd1,
      CAPTURE = 3'd2,
      ACCUM   = 3'd3,
      UPDATE  = 3'd4
   } state_t;

endpackage

// File: rtl/accel_position_filter_axis_avg_window.sv
// One axis: sample register, circular moving-average window and dead-zone output hysteresis.
module accel_position_filter_axis_avg_window
   import accel_position_filter_pkg::*;
#(
   parameter int unsigned LOG2_TAPS = 3,
   parameter int unsigned DEAD_ZONE = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               i_capture,
   input  logic               i_accum,
   input  logic               i_update,
   input  logic               i_prime,
   input  logic [ACCEL_W-1:0] i_sample,
   output logic [ACCEL_W-1:0] o_pos,
   output logic               o_move_c
);

   localparam int unsigned TAPS   = 2 ** LOG2_TAPS;
   localparam int unsigned SUM_W  = ACCEL_W + LOG2_TAPS;
   localparam int unsigned DIFF_W = ACCEL_W + 1;

   logic [ACCEL_W-1:0]       r_sample;
   logic [ACCEL_W-1:0]       r_pos;
   logic [ACCEL_W-1:0]       r_buf [TAPS];
   logic [SUM_W-1:0]         r_sum;
   logic [LOG2_TAPS-1:0]     r_idx;
   logic [ACCEL_W-1:0]       w_avg;
   logic signed [DIFF_W-1:0] w_diff;
   logic [DIFF_W-1:0]        w_mag;

   assign w_avg    = ACCEL_W'(r_sum >> LOG2_TAPS);
   assign w_diff   = $signed({1'b0, w_avg}) - $signed({1'b0, r_pos});
   assign w_mag    = w_diff[DIFF_W-1] ? DIFF_W'(-w_diff) : DIFF_W'(w_diff);
   // The priming update bypasses the dead zone so the first average always lands.
   assign o_move_c = i_update && (i_prime || (w_mag > DIFF_W'(DEAD_ZONE)));
   assign o_pos    = r_pos;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sample <= '0;
      end else if (i_capture) begin
         r_sample <= i_sample;
      end
   end

   // Running sum tracks the window contents; subtract-then-add wraps harmlessly in SUM_W bits.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sum <= '0;
         r_idx <= '0;
         for (int i = 0; i < int'(TAPS); i++) begin
            r_buf[i] <= '0;
         end
      end else if (i_accum) begin
         if (i_prime) begin
            for (int i = 0; i < int'(TAPS); i++) begin
               r_buf[i] <= r_sample;
            end
            r_sum <= SUM_W'(r_sample) << LOG2_TAPS;
         end else begin
            r_buf[r_idx] <= r_sample;
            r_sum        <= r_sum - SUM_W'(r_buf[r_idx]) + SUM_W'(r_sample);
            r_idx        <= r_idx + LOG2_TAPS'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pos <= POS_CENTER;
      end else if (o_move_c) begin
         r_pos <= w_avg;
      end
   end

endmodule

// File: rtl/accel_position_filter.sv
// Samples raw X/Y accelerometer readings at a fixed rate and emits smoothed, jitter-free positions.
module accel_position_filter
   import accel_position_filter_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV = 50000,
   parameter int unsigned LOG2_TAPS  = 3,
   parameter int unsigned DEAD_ZONE  = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [ACCEL_W-1:0] accel_x_in,
   input  logic [ACCEL_W-1:0] accel_y_in,
   input  logic               freeze,
   output logic [ACCEL_W-1:0] pos_x_out,
   output logic [ACCEL_W-1:0] pos_y_out,
   output logic               pos_valid
);

   localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             w_tick;
   state_t           r_state;
   state_t           w_next;
   logic             r_prime;
   logic             w_set_prime;
   logic             w_capture;
   logic             w_accum;
   logic             w_update;
   logic             w_move_x;
   logic             w_move_y;
   logic             r_pos_valid;

   assign w_tick    = (r_cnt == CNT_W'(SAMPLE_DIV - 1)) && !freeze;
   assign pos_valid = r_pos_valid;

   // Sample-rate divider; freeze parks it so no tick is lost or duplicated on release.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (!freeze) begin
         if (r_cnt == CNT_W'(SAMPLE_DIV - 1)) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= PRIME;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_set_prime = 1'b0;
      w_capture   = 1'b0;
      w_accum     = 1'b0;
      w_update    = 1'b0;
      case (r_state)
         PRIME: begin
            if (w_tick) begin
               w_set_prime = 1'b1;
               w_next      = CAPTURE;
            end
         end
         IDLE: begin
            if (w_tick) begin
               w_next = CAPTURE;
            end
         end
         CAPTURE: begin
            w_capture = 1'b1;
            w_next    = ACCUM;
         end
         ACCUM: begin
            w_accum = 1'b1;
            w_next  = UPDATE;
         end
         UPDATE: begin
            w_update = 1'b1;
            w_next   = IDLE;
         end
         default: w_next = PRIME;
      endcase
   end

   // Prime stays set through UPDATE so that update also skips the dead-zone test.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_prime <= 1'b0;
      end else if (w_set_prime) begin
         r_prime <= 1'b1;
      end else if (w_update) begin
         r_prime <= 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pos_valid <= 1'b0;
      end else begin
         r_pos_valid <= w_move_x | w_move_y;
      end
   end

   accel_position_filter_axis_avg_window #(
      .LOG2_TAPS (LOG2_TAPS),
      .DEAD_ZONE (DEAD_ZONE)
   ) u_axis_x (
      .clock     (clock),
      .reset     (reset),
      .i_capture (w_capture),
      .i_accum   (w_accum),
      .i_update  (w_update),
      .i_prime   (r_prime),
      .i_sample  (accel_x_in),
      .o_pos     (pos_x_out),
      .o_move_c  (w_move_x)
   );

   accel_position_filter_axis_avg_window #(
      .LOG2_TAPS (LOG2_TAPS),
      .DEAD_ZONE (DEAD_ZONE)
   ) u_axis_y (
      .clock     (clock),
      .reset     (reset),
      .i_capture (w_capture),
      .i_accum   (w_accum),
      .i_update  (w_update),
      .i_prime   (r_prime),
      .i_sample  (accel_y_in),
      .o_pos     (pos_y_out),
      .o_move_c  (w_move_y)
   );

endmodule

// File: tb/tb_accel_position_filter.sv
// Directed bench for accel_position_filter with hand-computed averages and dead-zone outcomes.
module tb_accel_position_filter;
   import accel_position_filter_pkg::*;

   localparam int SD = 8;

   logic       clock;
   logic       reset;
   logic       freeze;
   logic [8:0] ax;
   logic [8:0] ay;
   logic [8:0] pos_x_out;
   logic [8:0] pos_y_out;
   logic       pos_valid;

   int n_checks;
   int n_fail;

   int exp2_x [8] = '{300, 300, 303, 303, 303, 306, 306, 306};
   int exp2_p [8] = '{0, 0, 1, 0, 0, 1, 0, 0};

   accel_position_filter #(
      .SAMPLE_DIV (SD),
      .LOG2_TAPS  (3),
      .DEAD_ZONE  (2)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .accel_x_in (ax),
      .accel_y_in (ay),
      .freeze     (freeze),
      .pos_x_out  (pos_x_out),
      .pos_y_out  (pos_y_out),
      .pos_valid  (pos_valid)
   );

   always #10 clock = ~clock;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One sample period from a pulse-aligned negedge; counts cycles pos_valid was high.
   task automatic step(output int pulses);
      pulses = 0;
      repeat (SD) begin
         @(negedge clock);
         if (pos_valid) pulses++;
      end
   endtask

   task automatic wait_pulse(output int cycles);
      cycles = 0;
      do begin
         @(negedge clock);
         cycles++;
      end while (!pos_valid && cycles < 100);
   endtask

   initial begin
      int p;
      int tot;
      int c;
      n_checks = 0;
      n_fail   = 0;
      clock    = 1'b0;
      reset    = 1'b1;
      freeze   = 1'b0;
      ax       = 9'd300;
      ay       = 9'd200;

      // Reset state and priming
      repeat (3) @(negedge clock);
      check("rst_x", int'(pos_x_out), 256);
      check("rst_y", int'(pos_y_out), 256);
      check("rst_valid", int'(pos_valid), 0);
      reset = 1'b0;
      wait_pulse(c);
      check("prime_latency", c, SD + 3);
      check("prime_x", int'(pos_x_out), 300);
      check("prime_y", int'(pos_y_out), 200);
      step(p);
      check("prime_single_pulse", p, 0);

      // Dead-zone ramp 300 -> 308
      ax  = 9'd308;
      tot = 0;
      for (int k = 0; k < 8; k++) begin
         step(p);
         tot += p;
         check($sformatf("ramp_x_%0d", k + 1), int'(pos_x_out), exp2_x[k]);
         check($sformatf("ramp_p_%0d", k + 1), p, exp2_p[k]);
      end
      check("ramp_total_pulses", tot, 2);
      check("ramp_y_hold", int'(pos_y_out), 200);

      // Y-only move beyond the dead zone
      ay = 9'd240;
      step(p);
      check("yonly_x", int'(pos_x_out), 306);
      check("yonly_y", int'(pos_y_out), 205);
      check("yonly_p", p, 1);

      // Freeze for 5 periods while inputs change
      freeze = 1'b1;
      ax     = 9'd300;
      ay     = 9'd300;
      tot    = 0;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin
            ax = 9'd400;
            ay = 9'd400;
         end
         step(p);
         tot += p;
      end
      check("frz_pulses", tot, 0);
      check("frz_x", int'(pos_x_out), 306);
      check("frz_y", int'(pos_y_out), 205);
      freeze = 1'b0;
      step(p);
      check("thaw1_x", int'(pos_x_out), 319);
      check("thaw1_y", int'(pos_y_out), 230);
      check("thaw1_p", p, 1);
      step(p);
      check("thaw2_x", int'(pos_x_out), 331);
      check("thaw2_y", int'(pos_y_out), 255);
      check("thaw2_p", p, 1);

      // Reset during ACCUM, then re-prime
      repeat (6) @(negedge clock);
      check("in_accum", int'(dut.r_state), int'(ACCUM));
      reset = 1'b1;
      ax    = 9'd50;
      ay    = 9'd60;
      #1;
      check("mid_rst_x", int'(pos_x_out), 256);
      check("mid_rst_y", int'(pos_y_out), 256);
      check("mid_rst_valid", int'(pos_valid), 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      wait_pulse(c);
      check("reprime_latency", c, SD + 3);
      check("reprime_x", int'(pos_x_out), 50);
      check("reprime_y", int'(pos_y_out), 60);

      // Buffer wrap: prime at 100 then 16 samples of 180
      @(negedge clock);
      reset = 1'b1;
      ax    = 9'd100;
      ay    = 9'd100;
      @(negedge clock);
      reset = 1'b0;
      wait_pulse(c);
      check("wrap_prime_latency", c, SD + 3);
      check("wrap_prime_x", int'(pos_x_out), 100);
      ax = 9'd180;
      for (int k = 1; k <= 16; k++) begin
         step(p);
         check($sformatf("wrap_x_%0d", k), int'(pos_x_out), (k <= 8) ? 100 + 10 * k : 180);
         check($sformatf("wrap_p_%0d", k), p, (k <= 8) ? 1 : 0);
      end
      check("wrap_y", int'(pos_y_out), 100);
      check("wrap_sum", int'(dut.u_axis_x.r_sum), 1440);
      check("wrap_idx", int'(dut.u_axis_x.r_idx), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
